// File: rtl/sma_pkg.sv
// Shared types and width helpers for the multi-channel simple moving average.
package sma_pkg;

    // Pass sequencer: one Rd/Upd pair per channel, then a single Done cycle.
    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StUpd,
        StDone
    } sma_state_e;

    // Running sums must hold up to 2^max_log2_win full-scale samples.
    function automatic int unsigned sum_width(input int unsigned data_w,
                                              input int unsigned max_log2_win);
        return data_w + max_log2_win;
    endfunction

    // Channel index width; at least one bit so the address concat stays legal.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // RAM address = {channel, write pointer}.
    function automatic int unsigned addr_width(input int unsigned num_ch,
                                               input int unsigned max_log2_win);
        return ch_width(num_ch) + max_log2_win;
    endfunction

    // Width needed to hold a window selector in 0..max_log2_win.
    function automatic int unsigned sel_width(input int unsigned max_log2_win);
        return $clog2(max_log2_win + 1);
    endfunction

endpackage

// File: rtl/sma_mc_ram.sv
// Single-port synchronous sample history RAM; read returns the pre-write contents.
module sma_mc_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Registered read with one-cycle latency; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sma_mc.sv
// Multi-channel simple moving average over a power-of-two window of 2^sel samples.
// Channels are processed serially through one shared history RAM.
module sma_mc
    import sma_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_LOG2_WIN = 13
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_update_strobe,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [31:0]              i_window_sel,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_filled,
    output logic                     o_overrun,
    output logic [31:0]              m_count,
    output logic [15:0]              m_N
);

    localparam int unsigned SUM_W  = sum_width(DATA_W, MAX_LOG2_WIN);
    localparam int unsigned CH_W   = ch_width(NUM_CH);
    localparam int unsigned ADDR_W = addr_width(NUM_CH, MAX_LOG2_WIN);
    localparam int unsigned SEL_W  = sel_width(MAX_LOG2_WIN);
    localparam int unsigned PTR_W  = MAX_LOG2_WIN;
    localparam int unsigned DEPTH  = NUM_CH << MAX_LOG2_WIN;

    sma_state_e                r_state;
    sma_state_e                w_state_d;
    logic [CH_W-1:0]           r_ch;
    logic                      r_pend;
    logic [SEL_W-1:0]          r_sel;
    logic [PTR_W-1:0]          r_ptr;
    logic [31:0]               r_count;
    logic                      r_filled;
    logic                      r_overrun;
    logic signed [DATA_W-1:0]  r_sample [NUM_CH];
    logic signed [DATA_W-1:0]  r_data   [NUM_CH];
    logic signed [SUM_W-1:0]   r_sum    [NUM_CH];

    logic                      w_accept;
    logic                      w_last_ch;
    logic [SEL_W-1:0]          w_sel_in;
    logic [31:0]               w_n;
    logic                      w_ram_en;
    logic                      w_ram_we;
    logic [ADDR_W-1:0]         w_addr;
    logic [DATA_W-1:0]         w_ram_rdata;
    logic signed [DATA_W-1:0]  w_new;
    logic signed [DATA_W-1:0]  w_old;
    logic signed [SUM_W-1:0]   w_sum_next;
    logic signed [DATA_W-1:0]  w_avg;

    // r_pend covers the cycle between acceptance and the first RAM read.
    assign o_busy    = r_pend | (r_state != StIdle);
    assign o_valid   = (r_state == StDone);
    assign o_filled  = r_filled;
    assign o_overrun = r_overrun;
    assign m_count   = r_count;
    assign w_n       = 32'd1 << r_sel;
    assign m_N       = w_n[15:0];
    assign w_accept  = i_update_strobe & ~o_busy;
    assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));
    assign w_addr    = {r_ch, r_ptr};
    assign w_sel_in  = (i_window_sel > 32'(MAX_LOG2_WIN)) ? SEL_W'(MAX_LOG2_WIN)
                                                          : i_window_sel[SEL_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign o_data[c*DATA_W +: DATA_W] = r_data[c];
    end

    sma_mc_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_addr),
        .i_wdata (w_new),
        .o_rdata (w_ram_rdata)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and RAM control.
    always_comb begin
        w_state_d = r_state;
        w_ram_en  = 1'b0;
        w_ram_we  = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_pend) begin
                    w_state_d = StRd;
                end
            end
            StRd: begin
                w_ram_en  = 1'b1;
                w_state_d = StUpd;
            end
            StUpd: begin
                w_ram_en  = 1'b1;
                w_ram_we  = 1'b1;
                w_state_d = w_last_ch ? StDone : StRd;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Per-channel sum update; history is ignored until the window has been filled once.
    always_comb begin
        w_new      = r_sample[r_ch];
        w_old      = (r_count < w_n) ? '0 : $signed(w_ram_rdata);
        w_sum_next = r_sum[r_ch] + SUM_W'(w_new) - SUM_W'(w_old);
        w_avg      = DATA_W'(w_sum_next >>> r_sel);
    end

    // Datapath: sample capture, flush on window change, sums, outputs and window bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend    <= 1'b0;
            r_ch      <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_count   <= '0;
            r_filled  <= 1'b0;
            r_overrun <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_sample[c] <= '0;
                r_data[c]   <= '0;
                r_sum[c]    <= '0;
            end
        end else begin
            r_pend <= w_accept;
            if (i_update_strobe && o_busy) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_sample[c] <= i_data[c*DATA_W +: DATA_W];
                end
                if (w_sel_in != r_sel) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_sum[c] <= '0;
                    end
                    r_count  <= '0;
                    r_ptr    <= '0;
                    r_filled <= 1'b0;
                    r_sel    <= w_sel_in;
                end
            end
            if (r_state == StUpd) begin
                r_sum[r_ch]  <= w_sum_next;
                r_data[r_ch] <= w_avg;
                r_ch         <= w_last_ch ? '0 : r_ch + CH_W'(1);
                // Window bookkeeping lands on the edge into Done so it is visible with o_valid.
                if (w_last_ch) begin
                    r_ptr <= (32'(r_ptr) == w_n - 32'd1) ? '0 : r_ptr + PTR_W'(1);
                    if (r_count < w_n) begin
                        r_count <= r_count + 32'd1;
                        if (r_count + 32'd1 == w_n) begin
                            r_filled <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sma_mc.sv
// Directed self-checking bench for sma_mc with two channels and the default window range.
module tb_sma_mc;

    localparam int unsigned NUM_CH       = 2;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned MAX_LOG2_WIN = 13;

    logic                     i_clk;
    logic                     i_rst_n;
    logic                     i_update_strobe;
    logic [NUM_CH*DATA_W-1:0] i_data;
    logic [31:0]              i_window_sel;
    logic [NUM_CH*DATA_W-1:0] o_data;
    logic                     o_valid;
    logic                     o_busy;
    logic                     o_filled;
    logic                     o_overrun;
    logic [31:0]              m_count;
    logic [15:0]              m_N;

    logic signed [31:0] lane0;
    logic signed [31:0] lane1;
    assign lane0 = o_data[31:0];
    assign lane1 = o_data[63:32];

    int n_total;
    int n_pass;
    int lat;
    int nvalid;
    int guard;

    sma_mc #(
        .NUM_CH       (NUM_CH),
        .DATA_W       (DATA_W),
        .MAX_LOG2_WIN (MAX_LOG2_WIN)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_update_strobe (i_update_strobe),
        .i_data          (i_data),
        .i_window_sel    (i_window_sel),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .o_busy          (o_busy),
        .o_filled        (o_filled),
        .o_overrun       (o_overrun),
        .m_count         (m_count),
        .m_N             (m_N)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Wait for idle, issue one strobe, then wait (bounded) for o_valid; lat = edges after sampling.
    task automatic run_pass(input logic [31:0] sel, input int d0, input int d1);
        guard = 0;
        while (o_busy && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        i_window_sel    = sel;
        i_data          = {d1, d0};
        i_update_strobe = 1'b1;
        @(negedge i_clk);
        i_update_strobe = 1'b0;
        lat = 0;
        while (!o_valid && lat < 50) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_lane0"}, lane0, 0);
        check({tag, "_lane1"}, lane1, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_filled"}, o_filled, 0);
        check({tag, "_overrun"}, o_overrun, 0);
        check({tag, "_count"}, m_count, 0);
        check({tag, "_N"}, m_N, 1);
    endtask

    initial begin
        n_total         = 0;
        n_pass          = 0;
        i_rst_n         = 1'b0;
        i_update_strobe = 1'b0;
        i_data          = '0;
        i_window_sel    = '0;
        repeat (3) @(negedge i_clk);
        check_reset_state("rst");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Constant 100 on both channels, window 4: warm-up ramp 25, 50, 75, 100.
        for (int k = 1; k <= 10; k++) begin
            run_pass(32'd2, 100, 100);
            if (k == 1) check("const_lat", lat, 5);
            check($sformatf("const_l0_%0d", k), lane0, 25 * ((k < 4) ? k : 4));
            check($sformatf("const_l1_%0d", k), lane1, 25 * ((k < 4) ? k : 4));
            check($sformatf("const_filled_%0d", k), o_filled, (k >= 4) ? 1 : 0);
        end
        check("const_count", m_count, 4);
        check("const_N", m_N, 4);

        // Mixed signs, window 2: floor rounding during warm-up.
        run_pass(32'd1, -7, 7);
        check("mix1_l0", lane0, -4);
        check("mix1_l1", lane1, 3);
        check("mix1_filled", o_filled, 0);
        run_pass(32'd1, -7, 7);
        check("mix2_l0", lane0, -7);
        check("mix2_l1", lane1, 7);
        check("mix2_filled", o_filled, 1);
        run_pass(32'd1, -7, 7);
        check("mix3_l0", lane0, -7);

        // Window change 4 -> 8 flushes history.
        for (int k = 0; k < 6; k++) run_pass(32'd2, 100, 100);
        check("win_pre_l0", lane0, 100);
        check("win_pre_filled", o_filled, 1);
        run_pass(32'd3, 100, 100);
        check("win_l0", lane0, 12);
        check("win_l1", lane1, 12);
        check("win_count", m_count, 1);
        check("win_filled", o_filled, 0);
        check("win_N", m_N, 8);

        // Clamp to 8192 and full pointer wrap with ramp data.
        for (int k = 0; k <= 8192; k++) begin
            run_pass(32'd20, k, -k);
            if (k == 0) check("ramp_N", m_N, 8192);
            if (k == 8191) begin
                check("ramp_full_l0", lane0, 4095);
                check("ramp_full_l1", lane1, -4096);
                check("ramp_full_filled", o_filled, 1);
            end
            if (k == 8192) begin
                check("ramp_wrap_l0", lane0, 4096);
                check("ramp_wrap_l1", lane1, -4097);
                check("ramp_wrap_count", m_count, 8192);
            end
        end
        check("pre_ovr", o_overrun, 0);

        // Second strobe three cycles after the first is ignored and flagged.
        guard = 0;
        while (o_busy && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        i_window_sel    = 32'd2;
        i_data          = {32'd80, 32'd40};
        i_update_strobe = 1'b1;
        @(negedge i_clk);
        i_update_strobe = 1'b0;
        lat    = 0;
        nvalid = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                i_update_strobe = 1'b1;
                i_window_sel    = 32'd5;
                i_data          = {32'd800, 32'd400};
            end else begin
                i_update_strobe = 1'b0;
            end
            @(negedge i_clk);
            if (o_valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    lat = k;
                    check("ovr_l0", lane0, 10);
                    check("ovr_l1", lane1, 20);
                end
            end
        end
        check("ovr_lat", lat, 5);
        check("ovr_nvalid", nvalid, 1);
        check("ovr_flag", o_overrun, 1);
        check("ovr_N", m_N, 4);
        check("ovr_hold_l0", lane0, 10);

        // Reset in the middle of a pass aborts it.
        i_window_sel    = 32'd2;
        i_data          = {32'd40, 32'd40};
        i_update_strobe = 1'b1;
        @(negedge i_clk);
        i_update_strobe = 1'b0;
        @(negedge i_clk);
        check("mid_busy", o_busy, 1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_reset_state("mid_rst");
        i_rst_n = 1'b1;
        nvalid  = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            if (o_valid) nvalid++;
        end
        check("mid_nvalid", nvalid, 0);
        run_pass(32'd2, 40, 40);
        check("post_lat", lat, 5);
        check("post_l0", lane0, 10);
        check("post_l1", lane1, 10);
        check("post_count", m_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
